// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg: shared IEEE-754 single-precision constants and accumulator states (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_lzc27.sv
// ---------------------------------------------------------------------------
// fp_lzc27: combinational leading-zero counter for a 27-bit mantissa (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fp_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_accumulator.sv
// ---------------------------------------------------------------------------
// fp_accumulator: sequential IEEE-754 single-precision accumulator (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fp_accumulator
  import fp_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy
);

  acc_state_t state, state_next;

  logic [31:0]        acc, op;
  logic [COUNT_W-1:0] count;
  logic               last_flag;
  logic               special;
  logic [31:0]        spec_res;
  logic               x_sign, eff_sub;
  logic [9:0]         x_exp;
  logic [26:0]        x_man, y_man;
  logic [27:0]        sum;
  logic [26:0]        n_man;
  logic [9:0]         n_exp;
  logic               n_sign, n_zero;

  // ---------------- operand unpack / align ----------------
  logic        a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        w_special, a_ge;
  logic [31:0] w_spec_res, x_w, y_w, a_flush;
  logic [7:0]  d;
  logic [26:0] my_full, my_al;
  logic [53:0] w_sh;

  assign a_sign  = acc[31];
  assign b_sign  = op[31];
  assign a_zero  = (acc[30:23] == 8'd0);
  assign b_zero  = (op[30:23] == 8'd0);
  assign a_inf   = (acc[30:23] == 8'hFF) && (acc[22:0] == 23'd0);
  assign b_inf   = (op[30:23] == 8'hFF) && (op[22:0] == 23'd0);
  assign a_nan   = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'd0);
  assign b_nan   = (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
  assign a_flush = a_zero ? {a_sign, 31'd0} : acc;

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = a_flush;
    if (a_nan || b_nan)      w_spec_res = QNAN;
    else if (a_inf && b_inf) w_spec_res = (a_sign != b_sign) ? QNAN : acc;
    else if (a_inf)          w_spec_res = acc;
    else if (b_inf)          w_spec_res = op;
    else if (a_zero && b_zero) w_spec_res = {a_sign & b_sign, 31'd0};
    else if (b_zero)         w_spec_res = a_flush;
    else if (a_zero)         w_spec_res = op;
    else                     w_special  = 1'b0;
  end

  assign a_ge    = (acc[30:0] >= op[30:0]);
  assign x_w     = a_ge ? acc : op;
  assign y_w     = a_ge ? op : acc;
  assign d       = x_w[30:23] - y_w[30:23];
  assign my_full = {1'b1, y_w[22:0], 3'b000};
  assign w_sh    = {my_full, 27'd0} >> d;
  assign my_al   = (d >= 8'd27) ? 27'd1 : (w_sh[53:27] | {26'd0, |w_sh[26:0]});

  // ---------------- normalise ----------------
  logic [4:0]  lz;
  logic [26:0] w_nman;
  logic [9:0]  w_nexp;
  logic        w_nzero, w_nsign;

  fp_lzc27 u_lzc (
    .value (sum[26:0]),
    .count (lz)
  );

  always_comb begin
    w_nman  = sum[26:0] << lz;
    w_nexp  = x_exp - {5'd0, lz};
    w_nzero = 1'b0;
    w_nsign = x_sign;
    if (sum[27]) begin
      w_nman = {sum[27:2], sum[1] | sum[0]};
      w_nexp = x_exp + 10'd1;
    end else if (sum == 28'd0) begin
      w_nzero = 1'b1;
      w_nsign = 1'b0;
    end else if (w_nexp[9] || (w_nexp == 10'd0)) begin
      w_nzero = 1'b1;
    end
  end

  // ---------------- round to nearest even ----------------
  logic        round_up;
  logic [24:0] m25;
  logic [9:0]  r_exp;
  logic [22:0] r_frac;
  logic [31:0] w_final;

  assign round_up = n_man[2] & (n_man[1] | n_man[0] | n_man[3]);
  assign m25      = {1'b0, n_man[26:3]} + {24'd0, round_up};

  always_comb begin
    r_exp  = n_exp;
    r_frac = m25[22:0];
    if (m25[24]) begin
      r_exp  = n_exp + 10'd1;
      r_frac = m25[23:1];
    end
    if (special)                        w_final = spec_res;
    else if (n_zero)                    w_final = {n_sign, 31'd0};
    else if (r_exp >= 10'(EXP_MAX))     w_final = n_sign ? NEG_INF : POS_INF;
    else                                w_final = {n_sign, r_exp[7:0], r_frac};
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Specials still walk ADD/NORM so every operand costs the same 4 cycles.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 32'd0;
    out_count  = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (!clear && in_valid) state_next = ALIGN;
      end
      ALIGN: state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  state_next = ROUND;
      ROUND: state_next = last_flag ? DONE : IDLE;
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_count = count;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 32'd0;
      op        <= 32'd0;
      count     <= '0;
      last_flag <= 1'b0;
      special   <= 1'b0;
      spec_res  <= 32'd0;
      x_sign    <= 1'b0;
      eff_sub   <= 1'b0;
      x_exp     <= 10'd0;
      x_man     <= 27'd0;
      y_man     <= 27'd0;
      sum       <= 28'd0;
      n_man     <= 27'd0;
      n_exp     <= 10'd0;
      n_sign    <= 1'b0;
      n_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            acc   <= 32'd0;
            count <= '0;
          end else if (in_valid) begin
            op        <= in_data;
            last_flag <= in_last;
            if (count != '1) count <= count + COUNT_W'(1);
          end
        end
        ALIGN: begin
          special  <= w_special;
          spec_res <= w_spec_res;
          x_sign   <= x_w[31];
          eff_sub  <= x_w[31] ^ y_w[31];
          x_exp    <= {2'b00, x_w[30:23]};
          x_man    <= {1'b1, x_w[22:0], 3'b000};
          y_man    <= my_al;
        end
        ADD: begin
          sum <= eff_sub ? ({1'b0, x_man} - {1'b0, y_man})
                         : ({1'b0, x_man} + {1'b0, y_man});
        end
        NORM: begin
          n_man  <= w_nman;
          n_exp  <= w_nexp;
          n_sign <= w_nsign;
          n_zero <= w_nzero;
        end
        ROUND: acc <= w_final;
        DONE: begin
          if (out_ready) begin
            acc   <= 32'd0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
